// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor.
// Holds the counter encoding constants, the reference BTB entry layout for the
// default configuration, and the PC index/tag extraction helpers. The helpers
// work on a 64-bit PC and a runtime index width, so they serve any XLEN <= 64.
package bp_pkg;

    // Default configuration, used by the reference entry layout below.
    localparam int unsigned BP_XLEN    = 32;
    localparam int unsigned BP_ENTRIES = 16;
    localparam int unsigned BP_CNT_W   = 2;
    localparam int unsigned BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int unsigned BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

    // Weakly not-taken: largest value whose MSB is clear.
    function automatic int unsigned cnt_weak_nt(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

    // Weakly taken: smallest value whose MSB is set.
    function automatic int unsigned cnt_weak_t(input int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    localparam int unsigned CNT_WEAK_NT = cnt_weak_nt(BP_CNT_W);
    localparam int unsigned CNT_WEAK_T  = cnt_weak_t(BP_CNT_W);

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
        logic [BP_CNT_W-1:0] cnt;
        logic                jump;
    } btb_entry_t;

    // Word-aligned index: pc[idx_w+1:2], returned zero-extended.
    function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag: everything above the index, returned zero-extended.
    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational next-value logic for a saturating up/down counter.
// Ports:
//   cnt_i  - current counter value
//   load_i - replace the value with init_i (takes priority over inc/dec)
//   init_i - value loaded when load_i is set
//   inc_i  - count up, saturating at all-ones
//   dec_i  - count down, saturating at zero
//   cnt_o  - next counter value
module sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] init_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (load_i) begin
            cnt_o = init_i;
        end else if (inc_i && !dec_i) begin
            if (cnt_i != {CNT_W{1'b1}}) cnt_o = cnt_i + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating
// direction counters. Lookup is combinational in IF; resolution, redirect and
// table update happen in EX.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   bp_clear         - synchronous invalidate of all entries (fence.i)
//   if_pc            - IF-stage PC to look up
//   pred_taken       - IF prediction
//   pred_target      - predicted next PC
//   ex_*             - resolved EX-stage instruction and the prediction it carried
//   mispredict       - flush request; redirect_pc is the correct next PC
//   branch_cnt       - resolved control-flow instructions (saturating)
//   mispred_cnt      - mispredictions (saturating)
// Assumes XLEN <= 64 (index/tag helpers work on a 64-bit PC).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bp_clear,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_INIT_NT = CNT_W'(cnt_weak_nt(CNT_W));
    localparam logic [CNT_W-1:0] CNT_INIT_T  = CNT_W'(cnt_weak_t(CNT_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CNT_W-1:0] cnt;
        logic             jump;
    } entry_t;

    entry_t entry_q [ENTRIES];
    entry_t entry_d [ENTRIES];

    logic [PERF_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // ---------------------------------------------------------------- lookup
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    entry_t           if_entry;
    logic             if_hit;

    assign if_idx   = IDX_W'(pc_idx(64'(if_pc), IDX_W));
    assign if_tag   = TAG_W'(pc_tag(64'(if_pc), IDX_W));
    assign if_entry = entry_q[if_idx];
    assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);

    // Gating with reset keeps outputs at reset values for the whole reset window,
    // independent of when the flops actually clear.
    assign pred_taken  = reset && if_hit && (if_entry.jump || if_entry.cnt[CNT_W-1]);
    assign pred_target = pred_taken ? if_entry.target : if_pc + XLEN'(4);

    // ------------------------------------------------------------ resolution
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    entry_t           ex_entry;
    logic             ex_hit;
    logic             ex_cf;
    logic             ex_actual;
    logic [CNT_W-1:0] cnt_next;

    assign ex_idx    = IDX_W'(pc_idx(64'(ex_pc), IDX_W));
    assign ex_tag    = TAG_W'(pc_tag(64'(ex_pc), IDX_W));
    assign ex_entry  = entry_q[ex_idx];
    assign ex_hit    = ex_entry.valid && (ex_entry.tag == ex_tag);
    assign ex_cf     = ex_is_branch || ex_is_jump;
    assign ex_actual = ex_cf && (ex_is_jump || ex_taken);

    // Target compare only matters when actually taken; a not-taken outcome is
    // fully described by the direction bit.
    assign mispredict = reset && ex_valid &&
                        ((ex_actual != ex_pred_taken) ||
                         (ex_actual && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_actual ? ex_target : ex_pc + XLEN'(4);

    // A miss that allocates loads weakly-taken; a hit steps the existing counter.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .cnt_i  (ex_entry.cnt),
        .load_i (!ex_hit),
        .init_i (CNT_INIT_T),
        .inc_i  (ex_actual),
        .dec_i  (!ex_actual),
        .cnt_o  (cnt_next)
    );

    // ---------------------------------------------------------------- update
    always_comb begin
        entry_d = entry_q;
        if (bp_clear) begin
            // Clear wins over any same-cycle update; counters are left alone.
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entry_d[i].valid = 1'b0;
            end
        end else if (ex_valid) begin
            if (ex_cf) begin
                if (ex_hit) begin
                    entry_d[ex_idx].cnt  = cnt_next;
                    entry_d[ex_idx].jump = ex_is_jump;
                    if (ex_actual) entry_d[ex_idx].target = ex_target;
                end else if (ex_actual) begin
                    entry_d[ex_idx].valid  = 1'b1;
                    entry_d[ex_idx].tag    = ex_tag;
                    entry_d[ex_idx].target = ex_target;
                    entry_d[ex_idx].cnt    = cnt_next;
                    entry_d[ex_idx].jump   = ex_is_jump;
                end
            end else if (ex_hit && ex_pred_taken) begin
                // Non-control-flow instruction hit a stale or aliased entry.
                entry_d[ex_idx].valid = 1'b0;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_valid && ex_cf && (branch_cnt_q != {PERF_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + PERF_W'(1);
        end
        if (mispredict && (mispred_cnt_q != {PERF_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entry_q[i].valid  <= 1'b0;
                entry_q[i].tag    <= '0;
                entry_q[i].target <= '0;
                entry_q[i].cnt    <= CNT_INIT_NT;
                entry_q[i].jump   <= 1'b0;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entry_q[i] <= entry_d[i];
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. Two instances share stimulus: the
// default configuration and one with 4-bit performance counters to observe
// saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        bp_clear;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic        pred_taken;
    logic [31:0] pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    logic        p4_pred_taken;
    logic [31:0] p4_pred_target;
    logic        p4_mispredict;
    logic [31:0] p4_redirect_pc;
    logic [3:0]  p4_branch_cnt;
    logic [3:0]  p4_mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predictor u_dut (
        .clk            (clk),
        .reset          (reset),
        .bp_clear       (bp_clear),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    branch_predictor #(
        .PERF_W (4)
    ) u_dut_p4 (
        .clk            (clk),
        .reset          (reset),
        .bp_clear       (bp_clear),
        .if_pc          (if_pc),
        .pred_taken     (p4_pred_taken),
        .pred_target    (p4_pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (p4_mispredict),
        .redirect_pc    (p4_redirect_pc),
        .branch_cnt     (p4_branch_cnt),
        .mispred_cnt    (p4_mispred_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                          input logic tk, input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_is_branch   = br;
        ex_is_jump     = jmp;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic ex_idle();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_tk,
                          input logic [31:0] exp_tgt);
        if_pc = pc;
        settle();
        check({tag, "_taken"}, 64'(pred_taken), 64'(exp_tk));
        check({tag, "_target"}, 64'(pred_target), 64'(exp_tgt));
    endtask

    task automatic resolve(input string tag, input logic exp_mis, input logic [31:0] exp_redir);
        settle();
        check({tag, "_mispredict"}, 64'(mispredict), 64'(exp_mis));
        if (exp_mis) check({tag, "_redirect"}, 64'(redirect_pc), 64'(exp_redir));
    endtask

    task automatic perf(input string tag, input int exp_br, input int exp_mis);
        check({tag, "_branch_cnt"}, 64'(branch_cnt), 64'(exp_br));
        check({tag, "_mispred_cnt"}, 64'(mispred_cnt), 64'(exp_mis));
    endtask

    initial begin
        reset    = 1'b0;
        bp_clear = 1'b0;
        if_pc    = 32'h40;
        // Mispredicting pattern held during reset: mispredict must stay low.
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_mispredict", 64'(mispredict), 64'd0);
        check("rst_pred_taken", 64'(pred_taken), 64'd0);
        check("rst_pred_target", 64'(pred_target), 64'h44);
        ex_idle();
        reset = 1'b1;
        lookup("post_rst", 32'h40, 1'b0, 32'h44);
        perf("post_rst", 0, 0);

        // Taken branch allocates; same-cycle lookup must not see it yet.
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        resolve("alloc", 1'b1, 32'h20);
        lookup("no_bypass", 32'h40, 1'b0, 32'h44);
        tick();
        ex_idle();
        lookup("alloc_hit", 32'h40, 1'b1, 32'h20);
        perf("alloc", 1, 1);

        // cnt 2 -> 1: predicted taken, actually not taken.
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h20);
        resolve("nt1", 1'b1, 32'h44);
        tick();
        ex_idle();
        lookup("nt1", 32'h40, 1'b0, 32'h44);
        // cnt 1 -> 0, correctly predicted not taken.
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 32'h0);
        resolve("nt2", 1'b0, 32'h0);
        tick();
        // cnt stays 0.
        tick();
        ex_idle();
        perf("nt3", 4, 2);
        // One taken from 0 gives 1 (still not-taken); a wrapped 3 would predict taken.
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        ex_idle();
        lookup("sat_low", 32'h40, 1'b0, 32'h44);
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        ex_idle();
        lookup("retaken", 32'h40, 1'b1, 32'h20);
        perf("retaken", 6, 4);

        // Alias at same index, then stale-entry invalidation by a non-branch.
        lookup("alias", 32'h80, 1'b0, 32'h84);
        set_ex(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        resolve("stale", 1'b1, 32'h44);
        tick();
        ex_idle();
        lookup("stale_inv", 32'h40, 1'b0, 32'h44);
        perf("stale", 6, 5);

        // Jump allocation, then a changed jalr-style target via target compare.
        set_ex(1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
        resolve("jmp_alloc", 1'b1, 32'h200);
        tick();
        ex_idle();
        lookup("jmp_hit", 32'h60, 1'b1, 32'h200);
        set_ex(1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 32'h204, 1'b1, 32'h200);
        resolve("jmp_tgt", 1'b1, 32'h204);
        tick();
        ex_idle();
        lookup("jmp_new", 32'h60, 1'b1, 32'h204);
        perf("jmp", 8, 7);

        // Clear together with a taken allocation: clear wins.
        bp_clear = 1'b1;
        set_ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        bp_clear = 1'b0;
        ex_idle();
        lookup("clr_60", 32'h60, 1'b0, 32'h64);
        lookup("clr_40", 32'h40, 1'b0, 32'h44);
        lookup("clr_100", 32'h100, 1'b0, 32'h104);
        perf("clr", 9, 8);

        // Async reset pulse in mid-cycle.
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        lookup("pre_arst", 32'h40, 1'b1, 32'h20);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pred_taken", 64'(pred_taken), 64'd0);
        check("arst_pred_target", 64'(pred_target), 64'h44);
        check("arst_mispredict", 64'(mispredict), 64'd0);
        perf("arst", 0, 0);
        #1;
        reset = 1'b1;

        // 20 mispredicting updates: 4-bit counters saturate at 15.
        for (int i = 0; i < 20; i++) tick();
        ex_idle();
        check("p4_mispred_sat", 64'(p4_mispred_cnt), 64'd15);
        check("p4_branch_sat", 64'(p4_branch_cnt), 64'd15);
        perf("p32", 20, 20);
        set_ex(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h24, 1'b0, 32'h0);
        tick();
        ex_idle();
        check("p4_mispred_hold", 64'(p4_mispred_cnt), 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline.
- Replaces static "predict not-taken, resolve in EX, flush IF/ID and ID/EX" with a direct-mapped BTB plus per-entry saturating counters.
- Lookup is in IF. Update and misprediction detection are in EX.
- Provides the EX-stage redirect PC and performance counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB entries; must be a power of 2 and >= 2. IDX_W = log2(ENTRIES).
- CNT_W, 2, saturating counter width; must be >= 1.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- bp_clear  in  1  synchronous invalidate of all entries (fence.i).
- if_pc  in  XLEN  IF-stage PC.
- pred_taken  out  1  IF prediction.
- pred_target  out  XLEN  predicted next PC.
- ex_valid  in  1  EX holds a real, non-flushed instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_is_branch  in  1  conditional branch.
- ex_is_jump  in  1  jal/jalr.
- ex_taken  in  1  resolved direction.
- ex_target  in  XLEN  resolved target.
- ex_pred_taken  in  1  prediction carried down the pipeline.
- ex_pred_target  in  XLEN  predicted target carried down the pipeline.
- mispredict  out  1  flush IF/ID and ID/EX, load redirect_pc.
- redirect_pc  out  XLEN  correct next PC.
- branch_cnt  out  PERF_W  resolved control-flow instructions.
- mispred_cnt  out  PERF_W  mispredictions.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
  - Entry fields: valid, tag, target, cnt[CNT_W], jump.
- Reset (reset=0, asynchronous):
  - all valid=0; all cnt = weakly not-taken (2^(CNT_W-1)-1); perf counters = 0.
  - Outputs while in reset: pred_taken=0, pred_target=if_pc+4, mispredict=0.
  - Reset asserted mid-update discards that update.
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - pred_taken = hit & (jump | cnt MSB).
  - pred_target = pred_taken ? target : if_pc+4 (modulo 2^XLEN).
  - No bypass: a same-cycle update to the same index is visible only on the next cycle.
- Resolution (combinational):
  - cf = ex_is_branch | ex_is_jump; actual = cf & (ex_is_jump | ex_taken).
  - mispredict = ex_valid & ((actual != ex_pred_taken) | (actual & ex_target != ex_pred_target)).
  - redirect_pc = actual ? ex_target : ex_pc+4.
- Update (clock edge, only when ex_valid):
  - cf and hit:
    - cnt increments if taken, decrements otherwise, saturating at 0 and 2^CNT_W-1.
    - target is overwritten when taken.
    - jump bit is refreshed.
  - cf and miss:
    - If actual: allocate/replace the entry with valid=1, tag, target, cnt = weakly taken (2^(CNT_W-1)), jump.
    - If not taken: no allocation.
  - Not cf, hit, and ex_pred_taken (alias/stale entry): invalidate the entry.
  - ex_valid=0: no state change, mispredict=0.
- Perf counters:
  - branch_cnt increments on ex_valid & cf.
  - mispred_cnt increments on mispredict.
  - Both saturate at all-ones; no wrap.
- bp_clear:
  - Clears all valid bits next edge; cnt values are untouched.
  - Clear and update in the same cycle: clear wins, and the update's allocation is dropped.
  - Perf counters still count during clear.
- JALR targets that vary are handled purely by the target-compare mispredict path.

Decomposition:
- Shared package bp_pkg:
  - CNT_WEAK_NT / CNT_WEAK_T constants as functions of CNT_W.
  - btb_entry_t struct {valid, tag, target, cnt, jump}.
  - idx/tag extraction functions.
- One sub-module sat_counter:
  - Parametrised CNT_W; inputs inc/dec and init values.
  - Instantiated per entry, or as a shared combinational next-value function.

Test Plan:
- Reset, then if_pc=0x40 -> pred_taken=0, pred_target=0x44, branch_cnt=0, mispred_cnt=0.
- EX update ex_pc=0x40, branch, taken, ex_target=0x20, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x20, mispred_cnt=1. Next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x20.
- Then two not-taken updates at 0x40 (ex_pred_taken=1, then 0):
  - Counter goes 2 -> 1 -> 0; lookup predicts not-taken after the first.
  - First update gives mispredict=1 with redirect_pc=0x44; second gives mispredict=0.
  - A third not-taken update leaves cnt at 0.
- Alias: entry valid at 0x40. Lookup 0x80 (same idx 0) -> pred_taken=0. Non-branch update at 0x40 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x44; then lookup 0x40 misses.
- PERF_W=4: 20 consecutive mispredicting updates -> mispred_cnt=15 and holds there.
- bp_clear asserted in the same cycle as a taken allocation at 0x100 -> lookups at 0x40 and 0x100 both miss. Async reset pulse mid-cycle -> outputs return to reset values immediately, without waiting for a clock edge.
